// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin grant arbiter.
// Declarations only: state encoding, fixed sizes and idle decode patterns.
package rr_arbiter8_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   localparam logic [N_REQ-1:0] Y_IDLE_LO = 8'hFF;
   localparam logic [N_REQ-1:0] Y_IDLE_HI = 8'h00;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_onehot_decode.sv
// 3-to-8 one-hot grant decoder, active-low by default, inverted by i_opt.
// Purely combinational; when not valid every line sits at its inactive level.
module rr_onehot_decode
   import rr_arbiter8_pkg::*;
(
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_valid,
   input  logic             i_opt,
   output logic [N_REQ-1:0] o_y
);

   logic [N_REQ-1:0] w_lo;

   always_comb begin
      w_lo = ~(N_REQ'(1) << i_sel);
      if (i_valid) begin
         o_y = w_lo ^ {N_REQ{i_opt}};
      end else begin
         o_y = i_opt ? Y_IDLE_HI : Y_IDLE_LO;
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a hold limit and forced release.
// Grant visible the cycle after the sampling edge; every release costs one idle cycle.
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_en,
   input  logic             i_opt,
   output logic             o_gnt_valid,
   output logic [SEL_W-1:0] o_gnt_sel,
   output logic [N_REQ-1:0] o_gnt_y,
   output logic             o_preempt
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_preempt;
   logic             w_preempt_nxt;
   logic [SEL_W-1:0] w_pick;
   logic [SEL_W-1:0] w_idx;
   logic             w_found;
   logic             w_limit;

   // Scan starts just after the last released requester; the 3-bit sum wraps 7+1 to 0.
   always_comb begin : scan
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_idx = r_ptr + SEL_W'(i);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_limit = (MAX_HOLD != 0) && (r_cnt == LP_LAST);

   always_comb begin : fsm
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_preempt_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_en && w_found) begin
               w_state_nxt = ST_GRANT;
               w_sel_nxt   = w_pick;
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            // A release that coincides with the limit is a normal release.
            if (!i_req[r_sel] || w_limit) begin
               w_state_nxt   = ST_IDLE;
               w_ptr_nxt     = r_sel;
               w_preempt_nxt = i_req[r_sel];
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_ptr     <= SEL_W'(N_REQ - 1);
         r_cnt     <= '0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_preempt <= w_preempt_nxt;
      end
   end

   assign o_gnt_valid = (r_state == ST_GRANT);
   assign o_gnt_sel   = r_sel;
   assign o_preempt   = r_preempt;

   rr_onehot_decode u_decode (
      .i_sel   (r_sel),
      .i_valid (o_gnt_valid),
      .i_opt   (i_opt),
      .o_y     (o_gnt_y)
   );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed plus randomized bench for rr_arbiter8 against a behavioural round-robin model.
// The model tracks owner, last-released index and cycles held; outputs are checked 1 time unit after each edge.
module tb_rr_arbiter8;

   localparam int MH = 4;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_req;
   logic       i_en;
   logic       i_opt;
   logic       o_gnt_valid;
   logic [2:0] o_gnt_sel;
   logic [7:0] o_gnt_y;
   logic       o_preempt;

   int n_vec = 0;
   int n_err = 0;

   bit m_valid;
   bit m_pre;
   int m_sel;
   int m_ptr;
   int m_held;

   int ord[4] = '{0, 7, 0, 7};

   rr_arbiter8 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_en        (i_en),
      .i_opt       (i_opt),
      .o_gnt_valid (o_gnt_valid),
      .o_gnt_sel   (o_gnt_sel),
      .o_gnt_y     (o_gnt_y),
      .o_preempt   (o_preempt)
   );

   always #5 i_clk = ~i_clk;

   function automatic void model_reset();
      m_valid = 1'b0;
      m_pre   = 1'b0;
      m_sel   = 0;
      m_ptr   = 7;
      m_held  = 0;
   endfunction

   // One rising edge of the reference: first requester after the last released one wins.
   function automatic void model_step();
      int c;
      m_pre = 1'b0;
      if (i_rst) begin
         model_reset();
      end else if (!m_valid) begin
         if (i_en) begin
            for (int k = 1; k <= 8; k++) begin
               c = (m_ptr + k) % 8;
               if (!m_valid && i_req[c]) begin
                  m_valid = 1'b1;
                  m_sel   = c;
                  m_held  = 1;
               end
            end
         end
      end else if (!i_req[m_sel]) begin
         m_valid = 1'b0;
         m_ptr   = m_sel;
      end else if (MH != 0 && m_held == MH) begin
         m_valid = 1'b0;
         m_ptr   = m_sel;
         m_pre   = 1'b1;
      end else begin
         m_held = m_held + 1;
      end
   endfunction

   task automatic tick();
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      logic [7:0] y;
      y = i_opt ? 8'h00 : 8'hFF;
      if (m_valid) y[m_sel] = ~y[m_sel];
      chk({tag, ".valid"}, 32'(o_gnt_valid), 32'(m_valid));
      if (m_valid) chk({tag, ".sel"}, 32'(o_gnt_sel), 32'(m_sel));
      chk({tag, ".preempt"}, 32'(o_preempt), 32'(m_pre));
      chk({tag, ".y"}, 32'(o_gnt_y), 32'(y));
   endtask

   task automatic pulse_reset(input string tag);
      i_rst = 1'b1;
      #1;
      model_reset();
      chk({tag, ".valid_now"}, 32'(o_gnt_valid), 32'd0);
      chk_model(tag);
      #1;
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;
      i_opt = 1'b0;
      i_en  = 1'b0;
      i_req = 8'h00;
      model_reset();

      // Reset state and polarity
      #2;
      chk("rst.y_lo", 32'(o_gnt_y), 32'h0000_00FF);
      chk("rst.valid", 32'(o_gnt_valid), 32'd0);
      chk("rst.sel", 32'(o_gnt_sel), 32'd0);
      chk("rst.preempt", 32'(o_preempt), 32'd0);
      i_opt = 1'b1;
      #1;
      chk("rst.y_hi", 32'(o_gnt_y), 32'h0000_0000);
      i_opt = 1'b0;
      tick();
      tick();
      i_rst = 1'b0;
      i_en  = 1'b1;
      tick();
      chk_model("idle");

      // Single request
      i_req = 8'h08;
      tick();
      chk_model("single.g");
      chk("single.sel", 32'(o_gnt_sel), 32'd3);
      chk("single.y", 32'(o_gnt_y), 32'h0000_00F7);
      tick();
      chk_model("single.hold");
      i_req = 8'h00;
      tick();
      chk("single.drop", 32'(o_gnt_valid), 32'd0);
      chk_model("single.drop");

      // Rotation between 0 and 7 from a fresh pointer
      pulse_reset("rot.rst");
      i_req = 8'h81;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("rot.sel", 32'(o_gnt_sel), 32'(ord[g]));
         chk_model("rot.g");
         tick();
         chk_model("rot.hold");
         i_req = 8'h81 & ~(8'h01 << ord[g]);
         tick();
         chk("rot.gap", 32'(o_gnt_valid), 32'd0);
         chk_model("rot.gap");
         i_req = 8'h81;
      end

      // Wrap: last grant 6, then 0 beats 6
      i_req = 8'h40;
      tick();
      chk_model("wrap.g6");
      i_req = 8'h00;
      tick();
      chk_model("wrap.rel6");
      i_req = 8'h41;
      tick();
      chk("wrap.sel", 32'(o_gnt_sel), 32'd0);
      chk_model("wrap.g0");
      i_req = 8'h00;
      tick();
      chk_model("wrap.rel0");

      // Preemption after MH cycles, then the next requester
      i_req = 8'h06;
      for (int c = 0; c < MH; c++) begin
         tick();
         chk("pre.sel", 32'(o_gnt_sel), 32'd1);
         chk_model("pre.hold");
      end
      tick();
      chk("pre.pulse", 32'(o_preempt), 32'd1);
      chk("pre.gap", 32'(o_gnt_valid), 32'd0);
      tick();
      chk("pre.next", 32'(o_gnt_sel), 32'd2);
      chk("pre.once", 32'(o_preempt), 32'd0);
      chk_model("pre.next");

      // A preempted sole requester comes straight back after the gap
      i_req = 8'h04;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_model("sole");
      end
      chk("sole.valid", 32'(o_gnt_valid), 32'd1);
      chk("sole.sel", 32'(o_gnt_sel), 32'd2);

      // Reset mid-grant, next grant restarts at requester 0
      pulse_reset("midrst");
      i_req = 8'hFF;
      tick();
      chk("midrst.next", 32'(o_gnt_sel), 32'd0);
      chk_model("midrst.next");

      // Enable low blocks new grants but leaves a live one alone
      i_req = 8'h00;
      tick();
      i_en  = 1'b0;
      i_req = 8'hFF;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("en0.valid", 32'(o_gnt_valid), 32'd0);
      end
      i_en = 1'b1;
      tick();
      chk_model("en1.g");
      i_en = 1'b0;
      tick();
      chk("en0.keep", 32'(o_gnt_valid), 32'd1);
      chk_model("en0.keep");
      i_req = 8'h00;
      i_en  = 1'b1;
      tick();
      chk_model("en.rel");

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset("rnd.rst");
         i_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) i_opt = ~i_opt;
         if ($urandom_range(0, 2) == 0) i_req = i_req ^ (8'h01 << $urandom_range(0, 7));
         tick();
         chk_model("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 3-to-8 select resource among 8 requesters.
- Selects one requester, holds the grant until that requester releases or a hold limit expires, then rotates priority.
- Drives the encoded index (o_gnt_sel) and the decoded one-hot grant (o_gnt_y).
- o_gnt_y is active-low by default; i_opt inverts it, matching the team's existing decoder polarity convention.

Parameters:
- N_REQ, 8: number of requesters. Fixed at 8; the decoder width depends on it.
- SEL_W, 3: width of o_gnt_sel.
- MAX_HOLD, 16: maximum consecutive grant cycles before forced release. 0 means no limit. Legal values are 0 or at least 2.
- CNT_W, 5: width of the hold counter. Must hold MAX_HOLD.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  8  request vector; bit k high means requester k wants the resource. Level-sensitive and held high for the whole use.
- i_en  in  1  arbitration enable. When low, no new grants are issued; a current grant is unaffected.
- i_opt  in  1  output polarity. 0 = active-low one-hot; 1 = active-high one-hot. Static configuration.
- o_gnt_valid  out  1  a grant is currently active.
- o_gnt_sel  out  3  index of the granted requester. Meaningful only while o_gnt_valid is high.
- o_gnt_y  out  8  decoded grant.
- o_preempt  out  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state = IDLE; o_gnt_valid = 0; o_gnt_sel = 0; o_preempt = 0.
  - Hold counter = 0; priority pointer ptr = 7, so requester 0 has top priority after reset.
- State IDLE:
  - o_gnt_valid = 0.
  - If i_en = 1 and i_req != 0, pick the first set bit scanning ptr+1, ptr+2, … modulo 8.
  - Register the picked index into o_gnt_sel, set o_gnt_valid = 1, clear the counter, go to GRANT.
  - Latency: request sampled at edge N, grant visible after edge N+1... precisely, o_gnt_valid is high in the cycle following the sampling edge.
  - If no request or i_en = 0, stay in IDLE.
- State GRANT:
  - o_gnt_valid = 1; the counter increments each cycle.
  - Normal release: i_req[o_gnt_sel] sampled low → ptr = o_gnt_sel, o_gnt_valid = 0, go to IDLE.
  - Forced release: MAX_HOLD != 0 and counter = MAX_HOLD-1 while the request is still high → same as normal release, plus o_preempt = 1 for exactly one cycle.
  - Release and limit in the same cycle count as a normal release; o_preempt stays 0.
- Turnaround:
  - Every release passes through at least one IDLE cycle with o_gnt_valid = 0.
  - Minimum gap between two grants is one cycle; back-to-back grants to different requesters are never adjacent.
- Round-robin rules:
  - Requests from other requesters during GRANT are ignored until IDLE.
  - A preempted sole requester is re-granted after the one-cycle gap.
  - The pointer updates only on release, never in IDLE.
- i_en:
  - Sampled only in IDLE.
  - Deasserting it during GRANT does not end the grant.
- Decode of o_gnt_y (combinational from registered state and i_opt):
  - When o_gnt_valid = 1: active-low = ~(1 << o_gnt_sel); XOR with {8{i_opt}}.
  - When o_gnt_valid = 0: all inactive, i.e. 8'hFF for i_opt = 0 and 8'h00 for i_opt = 1.
  - During reset: the inactive value for the current i_opt.
- Arithmetic: priority rotation uses 3-bit modulo-8 wrap (7+1 = 0). The counter saturates and never wraps within a grant.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE, GRANT).
  - N_REQ and SEL_W constants.
  - Inactive-pattern constants 8'hFF and 8'h00.
- Sub-module: rr_onehot_decode, a pure combinational block with inputs sel[2:0], valid, opt and output y[7:0]. It is also usable by other blocks.
- The priority scan stays inline in rr_arbiter8.

Test Plan:
- Reset and polarity: with i_rst = 1 and i_opt = 0, o_gnt_y = 8'hFF and o_gnt_valid = 0. Set i_opt = 1 → o_gnt_y = 8'h00.
- Single request: i_req = 8'h08 from edge 0 → o_gnt_valid = 1 and o_gnt_sel = 3 after edge 1; o_gnt_y = 8'hF7 (i_opt = 0). Drop i_req → valid = 0 on the next cycle.
- Rotation: i_req = 8'h81 held, each requester releases after 2 cycles → grant order 0, 7, 0, 7, with one valid-low cycle between grants.
- Wrap: ptr = 6 (last grant 6), then i_req = 8'h41 → grant goes to 0, not 6.
- Preemption: MAX_HOLD = 4, i_req = 8'h06 held → requester 1 holds 4 cycles, o_preempt pulses, 1 idle cycle, then requester 2 is granted.
- Reset mid-grant, and i_en = 0: assert i_rst during GRANT → valid = 0 immediately, and the next grant after reset goes to requester 0. With i_en = 0 and i_req = 8'hFF → no grant ever issued.
